// File: rtl/inst_mem_fetch.sv
// Parametrised instruction memory with a registered 1-cycle fetch behind a
// valid/ready handshake, fault reporting, flush, and a run-time program port.
module inst_mem_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 1024,
  parameter int unsigned     ADDR_W   = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [XLEN-1:0]   prog_wdata,
  output logic              prog_busy,
  output logic              prog_ack,
  output logic              prog_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PROG} state_t;

  state_t            state;
  logic [XLEN-1:0]   mem [DEPTH];

  logic              rsp_free;
  logic              accept;
  logic              req_mis, req_oor;
  logic              prog_mis, prog_oor;
  logic              do_write, bad_write;
  logic [IDX_W-1:0]  req_idx, prog_idx;

  // Address decode for both ports; misaligned wins over out of range
  assign req_mis   = req_addr[1:0] != 2'b00;
  assign req_oor   = req_addr[ADDR_W-1:2] >= WA_W'(DEPTH);
  assign req_idx   = req_addr[IDX_W+1:2];
  assign prog_mis  = prog_addr[1:0] != 2'b00;
  assign prog_oor  = prog_addr[ADDR_W-1:2] >= WA_W'(DEPTH);
  assign prog_idx  = prog_addr[IDX_W+1:2];

  assign rsp_free  = !rsp_valid || rsp_ready;
  assign req_ready = (state == S_RUN) && !prog_en && !flush && rsp_free;
  assign accept    = req_valid && req_ready;
  assign do_write  = (state == S_PROG) && prog_we && !prog_mis && !prog_oor;
  assign bad_write = (state == S_PROG) && prog_we && (prog_mis || prog_oor);

  // Single-port array: writes only in PROG, reads only in RUN
  always_ff @(posedge clk) begin
    if (do_write) mem[prog_idx] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      rsp_valid <= 1'b0;
      rsp_inst  <= NOP_INST;
      rsp_addr  <= '0;
      rsp_fault <= 2'b00;
      prog_busy <= 1'b0;
      prog_ack  <= 1'b0;
      prog_err  <= 1'b0;
    end else begin
      prog_ack <= do_write;
      if (bad_write) prog_err <= 1'b1;

      // Flush beats accept; accept replaces a retiring response without a bubble
      if (flush) begin
        rsp_valid <= 1'b0;
      end else if (accept) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= req_addr;
        if (req_mis) begin
          rsp_fault <= 2'b01;
          rsp_inst  <= NOP_INST;
        end else if (req_oor) begin
          rsp_fault <= 2'b10;
          rsp_inst  <= NOP_INST;
        end else begin
          rsp_fault <= 2'b00;
          rsp_inst  <= mem[req_idx];
        end
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        S_RUN: begin
          if (prog_en) begin
            if (rsp_free) begin
              state     <= S_PROG;
              prog_busy <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!prog_en) begin
            state <= S_RUN;
          end else if (rsp_free || flush) begin
            state     <= S_PROG;
            prog_busy <= 1'b1;
          end
        end
        S_PROG: begin
          if (!prog_en) begin
            state     <= S_RUN;
            prog_busy <= 1'b0;
          end
        end
        default: begin
          state     <= S_RUN;
          prog_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Self-checking bench for inst_mem_fetch: vector table, directed corner
// sequences and a randomized fetch phase against a reference model.
module tb_inst_mem_fetch;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, flush;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_inst, rsp_addr;
  logic [1:0]  rsp_fault;
  logic        prog_en, prog_we, prog_busy, prog_ack, prog_err;
  logic [31:0] prog_addr, prog_wdata;

  int checks = 0;
  int errors = 0;
  int ack_seen;

  logic [31:0] mmem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  fault;
    logic [31:0] inst;
  } vec_t;
  vec_t vecs [8];

  inst_mem_fetch #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_busy(prog_busy), .prog_ack(prog_ack),
    .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_inst"},  64'(rsp_inst), 64'(NOP));
    check({tag, "_rsp_addr"},  64'(rsp_addr), 64'd0);
    check({tag, "_rsp_fault"}, 64'(rsp_fault), 64'd0);
    check({tag, "_prog_busy"}, 64'(prog_busy), 64'd0);
    check({tag, "_prog_ack"},  64'(prog_ack), 64'd0);
    check({tag, "_prog_err"},  64'(prog_err), 64'd0);
  endtask

  task automatic prog_write(input logic [31:0] a, input logic [31:0] d, input logic exp_ack);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    check("prog_ack", 64'(prog_ack), 64'(exp_ack));
    if (prog_ack) ack_seen++;
    if (exp_ack) mmem[int'(a >> 2)] = d;
    prog_we = 1'b0;
  endtask

  function automatic logic [1:0] model_fault(input logic [31:0] a);
    if (a % 4 != 0) return 2'b01;
    if (a / 4 >= DEPTH) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    logic        m_valid;
    logic [31:0] m_addr, m_inst, ra;
    logic [1:0]  m_fault;
    logic        exp_rdy;

    rst = 1'b1; req_valid = 0; req_addr = 0; flush = 0; rsp_ready = 0;
    prog_en = 0; prog_we = 0; prog_addr = 0; prog_wdata = 0;
    ack_seen = 0;

    vecs[0] = '{32'h0,              2'b00, 32'h00500093};
    vecs[1] = '{32'h4,              2'b00, 32'h00300113};
    vecs[2] = '{32'h8,              2'b00, 32'h002081B3};
    vecs[3] = '{32'h2,              2'b01, NOP};
    vecs[4] = '{DEPTH * 4,          2'b10, NOP};
    vecs[5] = '{32'h3FFE_0002,      2'b01, NOP};
    vecs[6] = '{(DEPTH - 1) * 4,    2'b00, 32'hDEADBEEF};
    vecs[7] = '{32'hFFFF_FFFC,      2'b10, NOP};

    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Preload via PROG
    prog_en = 1'b1;
    tick();
    check("enter_prog_busy", 64'(prog_busy), 64'd1);
    prog_write(32'h0, 32'h00500093, 1'b1);
    prog_write(32'h4, 32'h00300113, 1'b1);
    prog_write(32'h8, 32'h002081B3, 1'b1);
    prog_write((DEPTH - 1) * 4, 32'hDEADBEEF, 1'b1);
    tick();
    check("prog_ack_idle", 64'(prog_ack), 64'd0);
    check("prog_ack_count", 64'(ack_seen), 64'd4);
    prog_en = 1'b0;
    tick();
    check("exit_prog_busy", 64'(prog_busy), 64'd0);

    // Back-to-back vector table with rsp_ready held high
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = vecs[i].addr;
      #1;
      check("vec_req_ready", 64'(req_ready), 64'd1);
      tick();
      check("vec_rsp_valid", 64'(rsp_valid), 64'd1);
      check("vec_rsp_addr",  64'(rsp_addr),  64'(vecs[i].addr));
      check("vec_rsp_fault", 64'(rsp_fault), 64'(vecs[i].fault));
      check("vec_rsp_inst",  64'(rsp_inst),  64'(vecs[i].inst));
    end
    req_valid = 1'b0;
    tick();
    check("vec_retire", 64'(rsp_valid), 64'd0);

    // Back-pressure holds the response and blocks new requests
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_addr",  64'(rsp_addr),  64'h4);
      check("bp_hold_inst",  64'(rsp_inst),  64'h00300113);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'd1);
    tick();
    check("bp_next_addr", 64'(rsp_addr), 64'h8);
    check("bp_next_inst", 64'(rsp_inst), 64'h002081B3);
    req_valid = 1'b0;
    tick();

    // Flush drops a held response and refuses the request that cycle
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    flush = 1'b1; req_addr = 32'h8;
    #1;
    check("flush_req_ready", 64'(req_ready), 64'd0);
    tick();
    check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    flush = 1'b0; rsp_ready = 1'b1;
    tick();
    check("post_flush_valid", 64'(rsp_valid), 64'd1);
    check("post_flush_addr",  64'(rsp_addr),  64'h8);
    req_valid = 1'b0;
    tick();

    // DRAIN until the held response is consumed, then PROG; sticky error
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0; prog_en = 1'b1;
    tick();
    check("drain_busy0", 64'(prog_busy), 64'd0);
    check("drain_held",  64'(rsp_valid), 64'd1);
    #1;
    check("drain_req_ready", 64'(req_ready), 64'd0);
    tick();
    check("drain_busy1", 64'(prog_busy), 64'd0);
    rsp_ready = 1'b1;
    tick();
    check("drain_to_prog", 64'(prog_busy), 64'd1);
    check("drain_retired", 64'(rsp_valid), 64'd0);
    prog_write(32'h1, 32'hBAD0BAD0, 1'b0);
    check("err_set", 64'(prog_err), 64'd1);
    prog_write(32'hC, 32'h12345678, 1'b1);
    check("err_sticky1", 64'(prog_err), 64'd1);
    prog_write(DEPTH * 4, 32'hBAD1BAD1, 1'b0);
    prog_write(32'h10, 32'hCAFEF00D, 1'b1);
    check("err_sticky2", 64'(prog_err), 64'd1);

    // Reset mid-PROG
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_prog");
    rst = 1'b0; prog_en = 1'b0;
    tick();

    // Reset mid-stall, then memory still holds earlier writes
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'hC;
    tick();
    check("new_word_inst", 64'(rsp_inst), 64'h12345678);
    req_valid = 1'b0; rst = 1'b1;
    tick();
    check_reset_outputs("rst_stall");
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    check("mem_kept0", 64'(rsp_inst), 64'h00500093);
    req_addr = 32'h10;
    tick();
    check("mem_kept4", 64'(rsp_inst), 64'hCAFEF00D);
    req_valid = 1'b0;
    tick();

    // Fill the whole array with random data for the random phase
    prog_en = 1'b1;
    tick();
    for (int i = 0; i < int'(DEPTH); i++) prog_write(32'(i * 4), $urandom, 1'b1);
    prog_en = 1'b0;
    tick();
    check("rnd_start_valid", 64'(rsp_valid), 64'd0);

    // Random fetch traffic against the reference model
    m_valid = 1'b0; m_addr = 0; m_inst = NOP; m_fault = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 7) ra = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else ra = $urandom;
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      req_addr  = ra;
      #1;
      exp_rdy = !flush && (!m_valid || rsp_ready);
      check("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
      if (flush) begin
        m_valid = 1'b0;
      end else if (req_valid && exp_rdy) begin
        m_valid = 1'b1;
        m_addr  = ra;
        m_fault = model_fault(ra);
        m_inst  = (m_fault == 2'b00) ? mmem[int'(ra >> 2)] : NOP;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      tick();
      check("rnd_rsp_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
        check("rnd_rsp_addr",  64'(rsp_addr),  64'(m_addr));
        check("rnd_rsp_fault", 64'(rsp_fault), 64'(m_fault));
        check("rnd_rsp_inst",  64'(rsp_inst),  64'(m_inst));
      end
    end
    req_valid = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
